wav_mcuintf_mbox_ctrl: RTL and testbench

WAV_MCUINTF_MBOX_CTRL -- requirements
Module: wav_mcuintf_mbox_ctrl

---
 rtl/wav_mcuintf_mbox_ctrl.sv | 159 +++++++++++++++
 tb/tb_wav_mcuintf_mbox_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wav_mcuintf_mbox_ctrl.sv
// Host<->MCU mailbox: host2mcu 4-phase handshake into a FIFO, mcu2host send FSM.
// Optional handshake timeout enabled by defining WAV_MCUINTF_MBOX_TIMEOUT_EN.
module wav_mcuintf_mbox_ctrl #(
  parameter int DWIDTH    = 32,
  parameter int IDWIDTH   = 8,
  parameter int DEPTH     = 4,
  parameter int TO_CYCLES = 1024
) (
  input  logic                       i_hclk,
  input  logic                       i_hreset,
  input  logic                       i_h2m_req,
  input  logic [IDWIDTH-1:0]         i_h2m_id,
  input  logic [DWIDTH-1:0]          i_h2m_data,
  output logic                       o_h2m_ack,
  output logic                       o_mcu_irq,
  output logic [IDWIDTH-1:0]         o_mcu_id,
  output logic [DWIDTH-1:0]          o_mcu_data,
  input  logic                       i_mcu_pop,
  output logic [$clog2(DEPTH):0]     o_mcu_level,
  input  logic                       i_m2h_valid,
  input  logic [IDWIDTH-1:0]         i_m2h_id,
  input  logic [DWIDTH-1:0]          i_m2h_data,
  output logic                       o_m2h_ready,
  output logic                       o_m2h_req,
  output logic [IDWIDTH-1:0]         o_m2h_id,
  output logic [DWIDTH-1:0]          o_m2h_data,
  input  logic                       i_m2h_ack,
  output logic                       o_m2h_busy,
  output logic                       o_to_err,
  input  logic                       i_to_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = IDWIDTH + DWIDTH;

  typedef enum logic {H_IDLE, H_ACK} h_state_t;
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT_LOW} m_state_t;

  h_state_t         h_state, h_next;
  m_state_t         m_state, m_next;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic             full, empty, push, pop, accept, to_hit;
  logic [IDWIDTH-1:0] m_id_q;
  logic [DWIDTH-1:0]  m_data_q;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign pop   = i_mcu_pop && !empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    h_next = h_state;
    push   = 1'b0;
    case (h_state)
      H_IDLE: if (i_h2m_req && !full) begin
        push   = 1'b1;
        h_next = H_ACK;
      end
      H_ACK:  if (!i_h2m_req) h_next = H_IDLE;
      default: h_next = H_IDLE;
    endcase
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      h_state <= H_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
    end else begin
      h_state <= h_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty flag masks stale contents from the outputs.
  always_ff @(posedge i_hclk) begin
    if (push) mem[wr_ptr] <= {i_h2m_id, i_h2m_data};
  end

  assign o_h2m_ack   = (h_state == H_ACK);
  assign o_mcu_irq   = !empty;
  assign o_mcu_level = level;
  assign {o_mcu_id, o_mcu_data} = empty ? '0 : mem[rd_ptr];

  // Send FSM; a timeout overrides any pending transition and returns to idle.
  always_comb begin
    m_next = m_state;
    accept = 1'b0;
    case (m_state)
      M_IDLE: if (i_m2h_valid) begin
        accept = 1'b1;
        m_next = M_REQ;
      end
      M_REQ:      if (i_m2h_ack)  m_next = M_WAIT_LOW;
      M_WAIT_LOW: if (!i_m2h_ack) m_next = M_IDLE;
      default:    m_next = M_IDLE;
    endcase
    if (to_hit) m_next = M_IDLE;
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      m_state  <= M_IDLE;
      m_id_q   <= '0;
      m_data_q <= '0;
    end else begin
      m_state <= m_next;
      if (accept) begin
        m_id_q   <= i_m2h_id;
        m_data_q <= i_m2h_data;
      end
    end
  end

  assign o_m2h_ready = (m_state == M_IDLE);
  assign o_m2h_busy  = (m_state != M_IDLE);
  assign o_m2h_req   = (m_state == M_REQ);
  assign o_m2h_id    = m_id_q;
  assign o_m2h_data  = m_data_q;

`ifdef WAV_MCUINTF_MBOX_TIMEOUT_EN
  localparam int TCW = $clog2(TO_CYCLES + 1);
  logic [TCW-1:0] to_cnt;
  logic           to_err_q;

  // Count holds the number of completed cycles in the current busy state.
  assign to_hit = o_m2h_busy && (to_cnt == TCW'(TO_CYCLES - 1));

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (m_next != m_state || !o_m2h_busy) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + 1'b1;
      if (to_hit)        to_err_q <= 1'b1;
      else if (i_to_clr) to_err_q <= 1'b0;
    end
  end

  assign o_to_err = to_err_q;
`else
  logic unused_to_clr;
  assign unused_to_clr = i_to_clr;
  assign to_hit        = 1'b0;
  assign o_to_err      = 1'b0;
`endif

endmodule

// File: tb/tb_wav_mcuintf_mbox_ctrl.sv
// Directed self-checking bench for wav_mcuintf_mbox_ctrl (DEPTH=4, TO_CYCLES=16).
module tb_wav_mcuintf_mbox_ctrl;
  localparam int DW = 32;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          h2m_req, mcu_pop, m2h_valid, m2h_ack, to_clr;
  logic [IW-1:0] h2m_id, m2h_id_in;
  logic [DW-1:0] h2m_data, m2h_data_in;
  logic          h2m_ack, mcu_irq, m2h_ready, m2h_req, m2h_busy, to_err;
  logic [IW-1:0] mcu_id, m2h_id;
  logic [DW-1:0] mcu_data, m2h_data;
  logic [2:0]    mcu_level;

  int n_tests = 0;
  int n_fail  = 0;

  wav_mcuintf_mbox_ctrl #(.DWIDTH(DW), .IDWIDTH(IW), .DEPTH(4), .TO_CYCLES(16)) dut (
    .i_hclk(clk), .i_hreset(rst),
    .i_h2m_req(h2m_req), .i_h2m_id(h2m_id), .i_h2m_data(h2m_data), .o_h2m_ack(h2m_ack),
    .o_mcu_irq(mcu_irq), .o_mcu_id(mcu_id), .o_mcu_data(mcu_data), .i_mcu_pop(mcu_pop),
    .o_mcu_level(mcu_level),
    .i_m2h_valid(m2h_valid), .i_m2h_id(m2h_id_in), .i_m2h_data(m2h_data_in),
    .o_m2h_ready(m2h_ready), .o_m2h_req(m2h_req), .o_m2h_id(m2h_id), .o_m2h_data(m2h_data),
    .i_m2h_ack(m2h_ack), .o_m2h_busy(m2h_busy), .o_to_err(to_err), .i_to_clr(to_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete 4-phase host write into a FIFO with space.
  task automatic host_write(input logic [IW-1:0] id, input logic [DW-1:0] data);
    h2m_req = 1'b1; h2m_id = id; h2m_data = data;
    tick();
    check("hw_ack", h2m_ack, 1);
    h2m_req = 1'b0;
    tick();
    check("hw_ack_low", h2m_ack, 0);
  endtask

  initial begin
    rst = 1'b1; h2m_req = 0; h2m_id = 0; h2m_data = 0; mcu_pop = 0;
    m2h_valid = 0; m2h_id_in = 0; m2h_data_in = 0; m2h_ack = 0; to_clr = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_ack", h2m_ack, 0);
    check("rst_irq", mcu_irq, 0);
    check("rst_level", mcu_level, 0);
    check("rst_head", {mcu_id, mcu_data}, 0);
    check("rst_ready", m2h_ready, 1);
    check("rst_req", m2h_req, 0);
    check("rst_busy", m2h_busy, 0);
    check("rst_err", to_err, 0);

    // Single message with full 4-phase handshake, then pop.
    h2m_req = 1'b1; h2m_id = 8'h12; h2m_data = 32'hDEADBEEF;
    tick();
    check("w1_ack", h2m_ack, 1);
    check("w1_irq", mcu_irq, 1);
    check("w1_head", {mcu_id, mcu_data}, {8'h12, 32'hDEADBEEF});
    tick();
    check("w1_ack_hold", h2m_ack, 1);
    check("w1_no_repush", mcu_level, 1);
    h2m_req = 1'b0;
    tick();
    check("w1_ack_drop", h2m_ack, 0);
    mcu_pop = 1'b1;
    tick();
    mcu_pop = 1'b0;
    check("w1_pop_irq", mcu_irq, 0);
    check("w1_pop_head", {mcu_id, mcu_data}, 0);

    // Fill to DEPTH, fifth write backpressured until a pop frees space.
    for (int i = 0; i < 4; i++) host_write(8'h20 + 8'(i), 32'h100 + 32'(i));
    check("fill_level", mcu_level, 4);
    h2m_req = 1'b1; h2m_id = 8'h24; h2m_data = 32'h104;
    tick(); tick();
    check("full_no_ack", h2m_ack, 0);
    check("full_level", mcu_level, 4);
    check("full_head", {mcu_id, mcu_data}, {8'h20, 32'h100});
    mcu_pop = 1'b1;
    tick();
    mcu_pop = 1'b0;
    check("freed_level", mcu_level, 3);
    tick();
    check("fifth_ack", h2m_ack, 1);
    check("fifth_level", mcu_level, 4);
    h2m_req = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", {mcu_id, mcu_data}, {8'h20 + 8'(i), 32'h100 + 32'(i)});
      mcu_pop = 1'b1;
      tick();
      mcu_pop = 1'b0;
    end
    check("drain_level", mcu_level, 0);

    // Simultaneous push/pop with one entry resident: level constant, order kept, pointers wrap.
    host_write(8'h40, 32'hA000_0000);
    for (int k = 1; k <= 8; k++) begin
      check("pp_head", {mcu_id, mcu_data}, {8'h40 + 8'(k - 1), 32'hA000_0000 + 32'(k - 1)});
      h2m_req = 1'b1; h2m_id = 8'h40 + 8'(k); h2m_data = 32'hA000_0000 + 32'(k); mcu_pop = 1'b1;
      tick();
      check("pp_level", mcu_level, 1);
      h2m_req = 1'b0; mcu_pop = 1'b0;
      tick();
    end
    check("pp_last", {mcu_id, mcu_data}, {8'h48, 32'hA000_0008});
    mcu_pop = 1'b1;
    tick();
    check("pop_to_empty", mcu_level, 0);
    tick();
    mcu_pop = 1'b0;
    check("pop_empty_level", mcu_level, 0);
    check("pop_empty_irq", mcu_irq, 0);
    host_write(8'h55, 32'h5555);
    check("after_empty_pop", {mcu_id, mcu_data}, {8'h55, 32'h5555});
    check("after_empty_level", mcu_level, 1);
    mcu_pop = 1'b1;
    tick();
    mcu_pop = 1'b0;

    // MCU to host send handshake.
    m2h_valid = 1'b1; m2h_id_in = 8'h34; m2h_data_in = 32'h1;
    #1;
    check("snd_ready_idle", m2h_ready, 1);
    tick();
    m2h_valid = 1'b0;
    check("snd_req", m2h_req, 1);
    check("snd_payload", {m2h_id, m2h_data}, {8'h34, 32'h1});
    check("snd_busy", m2h_busy, 1);
    check("snd_ready_busy", m2h_ready, 0);
    m2h_valid = 1'b1; m2h_id_in = 8'h99; m2h_data_in = 32'hFFFF;
    tick();
    m2h_valid = 1'b0;
    check("snd_reject", {m2h_id, m2h_data}, {8'h34, 32'h1});
    check("snd_req_hold", m2h_req, 1);
    m2h_ack = 1'b1;
    tick();
    check("snd_req_drop", m2h_req, 0);
    check("snd_wait_low", m2h_ready, 0);
    m2h_ack = 1'b0;
    tick();
    check("snd_idle", m2h_ready, 1);
    check("snd_hold", {m2h_id, m2h_data}, {8'h34, 32'h1});

    // Host never acks.
    m2h_valid = 1'b1; m2h_id_in = 8'h56; m2h_data_in = 32'h2;
    tick();
    m2h_valid = 1'b0;
`ifdef WAV_MCUINTF_MBOX_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check("to_req_before", m2h_req, 1);
    check("to_err_before", to_err, 0);
    tick();
    check("to_req_after", m2h_req, 0);
    check("to_err_set", to_err, 1);
    check("to_ready", m2h_ready, 1);
    to_clr = 1'b1;
    tick();
    to_clr = 1'b0;
    check("to_err_clr", to_err, 0);
    // A clear landing on the timeout edge loses to the set.
    m2h_valid = 1'b1;
    tick();
    m2h_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    to_clr = 1'b1;
    tick();
    to_clr = 1'b0;
    check("to_set_wins", to_err, 1);
    to_clr = 1'b1;
    tick();
    to_clr = 1'b0;
    check("to_err_clr2", to_err, 0);
`else
    for (int i = 0; i < 40; i++) tick();
    check("noto_req", m2h_req, 1);
    check("noto_err", to_err, 0);
    m2h_ack = 1'b1;
    tick();
    m2h_ack = 1'b0;
    tick();
    check("noto_idle", m2h_ready, 1);
`endif

    // Reset mid-handshake on both sides with data queued.
    host_write(8'h70, 32'h7);
    h2m_req = 1'b1; h2m_id = 8'h71; h2m_data = 32'h8;
    m2h_valid = 1'b1; m2h_id_in = 8'h72; m2h_data_in = 32'h9;
    tick();
    m2h_valid = 1'b0;
    check("pre_rst_ack", h2m_ack, 1);
    check("pre_rst_req", m2h_req, 1);
    check("pre_rst_level", mcu_level, 2);
    rst = 1'b1; h2m_req = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_ack", h2m_ack, 0);
    check("mid_rst_req", m2h_req, 0);
    check("mid_rst_level", mcu_level, 0);
    check("mid_rst_ready", m2h_ready, 1);
    check("mid_rst_head", {mcu_id, mcu_data}, 0);
    check("mid_rst_payload", {m2h_id, m2h_data}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
